list_free: RTL and testbench

Linked-list reclaimer: an initiator on the allocator's pointer and memory ports that walks a singly-linked chain of heap cells and returns every cell to the free list. Each cell holds one DATA_SZ word, the pointer to the next cell, with NIL terminating the chain. It sits between the evaluator/GC control and the allocator. It issues one read and one free per cell on alternating cycles, so it never drives both allocator ports in the same cycle.

---
 rtl/list_free.sv | 170 +++++++++++++++++
 tb/tb_list_free.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/list_free.sv
// list_free: linked-list reclaimer.
// Walks a singly-linked chain of heap cells beginning at i_head and returns each
// cell to the allocator's free list. Every cell is handled in two cycles: a read
// of the cell, which yields the next pointer, and then a free of the cell. This
// means the read and free ports are never driven in the same cycle.
//
// Ports:
//   i_clk, i_rst_n      clock; asynchronous active-low reset
//   i_start, i_head     start strobe and head pointer (sampled in IDLE only)
//   o_busy              high while walking (READ/FREE)
//   o_done              one-cycle strobe on successful completion
//   o_count             cells freed by the current/last walk (saturating)
//   o_err               sticky error, cleared only by reset
//   o_rd, o_raddr       allocator read request/address
//   i_rdata             allocator read data, valid the cycle after o_rd
//   o_fr, o_faddr       allocator free request/address
//   i_aerr              allocator error strobe
//
// Optional feature: define LIST_FREE_BOUND_EN to limit a walk to MAX_CELLS
// cells. This catches cyclic or corrupt lists.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for i_start
// READ  | read request for cell cur
// FREE  | next pointer arriving on i_rdata; free cur when next is legal
// ERR   | absorbing error state; left only through reset

module list_free #(
   parameter int DATA_SZ   = 16,
   parameter int ADDR_SZ   = 8,
   parameter int MAX_CELLS = 255
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [DATA_SZ-1:0] i_head,
   output logic               o_busy,
   output logic               o_done,
   output logic [ADDR_SZ:0]   o_count,
   output logic               o_err,
   output logic               o_rd,
   output logic [DATA_SZ-1:0] o_raddr,
   input  logic [DATA_SZ-1:0] i_rdata,
   output logic               o_fr,
   output logic [DATA_SZ-1:0] o_faddr,
   input  logic               i_aerr
);

   localparam logic [DATA_SZ-1:0] NIL   = DATA_SZ'(1);
   localparam logic [DATA_SZ-1:0] UNDEF = '0;

`ifdef LIST_FREE_BOUND_EN
   localparam bit BOUND_EN = 1'b1;
`else
   localparam bit BOUND_EN = 1'b0;
`endif

   localparam logic [ADDR_SZ+1:0] BOUND = (ADDR_SZ+2)'(MAX_CELLS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      FREE = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t               state, state_nx;
   logic [DATA_SZ-1:0]   cur, cur_nx;
   logic [ADDR_SZ:0]     count_nx;
   logic                 done_nx;
   logic                 rd, fr;
   logic [ADDR_SZ+1:0]   count_p1;
   logic [ADDR_SZ:0]     count_sat;
   logic                 head_heap, next_heap, next_nil, next_ok, bound_hit;

   // A heap pointer carries tag nibble 4'h5 (MUT|VLT, not DIR).
   function automatic logic is_heap(input logic [DATA_SZ-1:0] v);
      return v[DATA_SZ-1 -: 4] == 4'h5;
   endfunction

   always_comb begin
      head_heap = is_heap(i_head);
      next_heap = is_heap(i_rdata);
      next_nil  = (i_rdata == NIL);
      next_ok   = next_heap || next_nil;
      // The extra MSB lets the count+1 carry be seen when the count saturates.
      count_p1  = {1'b0, o_count} + (ADDR_SZ+2)'(1);
      count_sat = count_p1[ADDR_SZ+1] ? o_count : count_p1[ADDR_SZ:0];
      // Freeing this cell would reach the bound while the chain still goes on.
      bound_hit = BOUND_EN && (count_p1 == BOUND) && !next_nil;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         cur     <= UNDEF;
         o_count <= '0;
         o_done  <= 1'b0;
      end else begin
         state   <= state_nx;
         cur     <= cur_nx;
         o_count <= count_nx;
         o_done  <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cur_nx   = cur;
      count_nx = o_count;
      done_nx  = 1'b0;
      rd       = 1'b0;
      fr       = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               if (i_head == NIL) begin
                  count_nx = '0;
                  done_nx  = 1'b1;
               end else if (head_heap) begin
                  cur_nx   = i_head;
                  count_nx = '0;
                  state_nx = READ;
               end else begin
                  state_nx = ERR;
               end
            end
         end
         READ: begin
            if (i_aerr) begin
               state_nx = ERR;
            end else begin
               rd       = 1'b1;
               state_nx = FREE;
            end
         end
         FREE: begin
            // The free is withheld on any error, so the cell stays allocated.
            if (i_aerr || !next_ok || bound_hit) begin
               state_nx = ERR;
            end else begin
               fr       = 1'b1;
               count_nx = count_sat;
               if (next_nil) begin
                  done_nx  = 1'b1;
                  state_nx = IDLE;
               end else begin
                  cur_nx   = i_rdata;
                  state_nx = READ;
               end
            end
         end
         ERR: begin
            state_nx = ERR;
         end
         default: begin
            state_nx = ERR;
         end
      endcase
   end

   assign o_busy  = (state == READ) || (state == FREE);
   assign o_err   = (state == ERR);
   assign o_rd    = rd;
   assign o_fr    = fr;
   assign o_raddr = rd ? cur : UNDEF;
   assign o_faddr = fr ? cur : UNDEF;

endmodule

// File: tb/tb_list_free.sv
// tb_list_free: scoreboard bench for list_free.
// A list-level reference model walks a heap image held in an associative array.
// For each start it predicts the timed event stream: reads, frees, done or error.
// A monitor pops the stream as the DUT presents each event.
`timescale 1ns/1ps

module tb_list_free;

`ifdef LIST_FREE_BOUND_EN
   localparam int TB_MAX   = 2;
   localparam bit TB_BOUND = 1'b1;
`else
   localparam int TB_MAX   = 255;
   localparam bit TB_BOUND = 1'b0;
`endif
   localparam int CNT_MAX = 511;
   localparam logic [15:0] NIL = 16'h0001;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [15:0] i_head = 16'h0000;
   logic        o_busy, o_done, o_err, o_rd, o_fr;
   logic [8:0]  o_count;
   logic [15:0] o_raddr, o_faddr;
   logic [15:0] i_rdata = 16'h0000;
   logic        i_aerr = 1'b0;

   list_free #(.DATA_SZ(16), .ADDR_SZ(8), .MAX_CELLS(TB_MAX)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_head(i_head),
      .o_busy(o_busy), .o_done(o_done), .o_count(o_count), .o_err(o_err),
      .o_rd(o_rd), .o_raddr(o_raddr), .i_rdata(i_rdata),
      .o_fr(o_fr), .o_faddr(o_faddr), .i_aerr(i_aerr)
   );

   always #5 i_clk = ~i_clk;

   localparam int K_RD = 0, K_FR = 1, K_DONE = 2, K_ERR = 3;
   typedef struct {int kind; int cyc; int val;} ev_t;
   ev_t exp_q[$];

   logic [15:0] mem [logic [15:0]];
   int  cyc = 0;
   int  c0;
   int  vectors = 0;
   int  miscompares = 0;
   bit  m_err = 0;
   int  m_count = 0;
   logic err_prev = 1'b0;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Allocator read port: one-cycle read latency, UNDEF for unknown cells.
   always @(posedge i_clk)
      if (o_rd) i_rdata <= mem.exists(o_raddr) ? mem[o_raddr] : 16'h0000;

   function automatic bit heap(input logic [15:0] v);
      return v[15:12] == 4'h5;
   endfunction

   function automatic string kname(input int k);
      case (k)
         K_RD:   return "rd";
         K_FR:   return "fr";
         K_DONE: return "done";
         default: return "err";
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic mon_pop(input int kind, input int val);
      ev_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected_%s: got %0h at cycle %0d, expected no event", kname(kind), val, cyc - c0);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.val != val) begin
            miscompares++;
            $display("FAIL event: got %s=%0h at cycle %0d, expected %s=%0h at cycle %0d",
                     kname(kind), val, cyc - c0, kname(e.kind), e.val, e.cyc - c0);
         end
      end
   endtask

   always @(negedge i_clk) begin
      if (i_rst_n) begin
         if (o_rd && o_fr) begin
            miscompares++;
            $display("FAIL overlap: got o_rd=1 o_fr=1 at cycle %0d, expected at most one", cyc - c0);
         end
         if (o_rd) mon_pop(K_RD, int'(o_raddr));
         if (o_fr) mon_pop(K_FR, int'(o_faddr));
         if (o_done) mon_pop(K_DONE, int'(o_count));
         if (o_err && !err_prev) mon_pop(K_ERR, int'(o_count));
      end
      err_prev = o_err;
   end

   function automatic void push(input int kind, input int rel, input int val);
      ev_t e;
      e.kind = kind; e.cyc = c0 + rel; e.val = val;
      exp_q.push_back(e);
   endfunction

   // The cell k read falls in cycle 2k-1 and its free in cycle 2k. After the
   // last free comes done. An error becomes visible one cycle after detection.
   task automatic model_walk(input logic [15:0] head, input int aerr_c);
      logic [15:0] cur, nxt;
      int k;
      if (m_err) return;
      if (head == NIL) begin
         m_count = 0;
         push(K_DONE, 1, 0);
         return;
      end
      if (!heap(head)) begin
         m_err = 1;
         push(K_ERR, 1, m_count);
         return;
      end
      m_count = 0;
      cur = head;
      for (k = 1; k < 4000; k++) begin
         if (aerr_c == 2*k-1) begin
            m_err = 1; push(K_ERR, 2*k, m_count); return;
         end
         push(K_RD, 2*k-1, int'(cur));
         nxt = mem.exists(cur) ? mem[cur] : 16'h0000;
         if (aerr_c == 2*k || !(nxt == NIL || heap(nxt)) ||
             (TB_BOUND && m_count + 1 == TB_MAX && nxt != NIL)) begin
            m_err = 1; push(K_ERR, 2*k+1, m_count); return;
         end
         push(K_FR, 2*k, int'(cur));
         m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
         if (nxt == NIL) begin
            push(K_DONE, 2*k+1, m_count); return;
         end
         cur = nxt;
      end
   endtask

   task automatic start_walk(input logic [15:0] head, input int aerr_c);
      @(posedge i_clk); #1;
      c0 = cyc;
      i_start = 1'b1;
      i_head  = head;
      model_walk(head, aerr_c);
      @(posedge i_clk); #1;
      i_start = 1'b0;
   endtask

   task automatic run_walk(input logic [15:0] head, input int aerr_c,
                           input int ign_c, input logic [15:0] ign_head);
      int budget;
      start_walk(head, aerr_c);
      budget = 4000;
      while (exp_q.size() > 0 && budget > 0) begin
         i_aerr = (aerr_c != 0 && cyc == c0 + aerr_c);
         if (ign_c != 0 && cyc == c0 + ign_c) begin
            i_start = 1'b1; i_head = ign_head;
         end else begin
            i_start = 1'b0;
         end
         @(posedge i_clk); #1;
         budget--;
      end
      i_aerr = 1'b0;
      i_start = 1'b0;
      if (budget == 0) begin
         miscompares++;
         $display("FAIL timeout: got %0d events pending, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge i_clk);
      #1;
      chk("end_busy", int'(o_busy), 0);
      chk("end_err", int'(o_err), int'(m_err));
      chk("end_count", int'(o_count), m_count);
   endtask

   task automatic do_reset();
      #1;
      i_rst_n = 1'b0;
      i_start = 1'b0;
      i_aerr  = 1'b0;
      #2;
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_done", int'(o_done), 0);
      chk("rst_count", int'(o_count), 0);
      chk("rst_err", int'(o_err), 0);
      chk("rst_rd", int'(o_rd), 0);
      chk("rst_fr", int'(o_fr), 0);
      chk("rst_raddr", int'(o_raddr), 0);
      chk("rst_faddr", int'(o_faddr), 0);
      exp_q.delete();
      m_err = 0;
      m_count = 0;
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
   endtask

   task automatic build_random(output logic [15:0] head, output int n);
      logic [15:0] a, prev;
      int r;
      logic [15:0] bad [4];
      bad[0] = 16'h0000; bad[1] = 16'h8005; bad[2] = 16'h0002; bad[3] = 16'h4123;
      mem.delete();
      n = $urandom_range(1, 6);
      prev = 16'h0000;
      head = 16'h0000;
      for (int i = 0; i < n; i++) begin
         do a = 16'h5000 | 16'($urandom_range(0, 4095)); while (mem.exists(a));
         mem[a] = NIL;
         if (i == 0) head = a; else mem[prev] = a;
         prev = a;
      end
      r = $urandom_range(0, 9);
      mem[prev] = (r < 8) ? NIL : bad[$urandom_range(0, 3)];
   endtask

   initial begin
      logic [15:0] h;
      int n, ac;
      do_reset();

      // Three-cell list.
      mem.delete();
      mem[16'h5000] = 16'h5001; mem[16'h5001] = 16'h5002; mem[16'h5002] = NIL;
      run_walk(16'h5000, 0, 0, 16'h0000);

      // NIL head, and a new start right after it.
      run_walk(NIL, 0, 0, 16'h0000);
      run_walk(16'h5000, 0, 0, 16'h0000);

      // Fixnum head errors; a later start is ignored.
      run_walk(16'h8005, 0, 0, 16'h0000);
      run_walk(16'h5000, 0, 0, 16'h0000);
      do_reset();

      // Chain ending in TRUE.
      mem.delete();
      mem[16'h5000] = 16'h0002;
      run_walk(16'h5000, 0, 0, 16'h0000);
      do_reset();

      // Allocator error during the second FREE of a three-cell walk.
      mem.delete();
      mem[16'h5000] = 16'h5001; mem[16'h5001] = 16'h5002; mem[16'h5002] = NIL;
      run_walk(16'h5000, 4, 0, 16'h0000);
      do_reset();

      // Cyclic list; the bound or an allocator double-free error ends it.
      mem.delete();
      mem[16'h5000] = 16'h5001; mem[16'h5001] = 16'h5000;
      run_walk(16'h5000, 6, 0, 16'h0000);
      do_reset();

      // Four-cell list with a start that is ignored in the middle of the walk.
      mem.delete();
      mem[16'h5000] = 16'h5001; mem[16'h5001] = 16'h5002;
      mem[16'h5002] = 16'h5003; mem[16'h5003] = NIL;
      mem[16'h5100] = NIL;
      run_walk(16'h5000, 0, 3, 16'h5100);
      if (m_err) do_reset();

      // Reset in the middle of a walk.
      start_walk(16'h5000, 0);
      repeat (2) @(posedge i_clk);
      do_reset();

      // Count saturation on a long list.
      mem.delete();
      for (int i = 0; i < 515; i++)
         mem[16'h5000 + 16'(i)] = (i == 514) ? NIL : 16'h5000 + 16'(i + 1);
      run_walk(16'h5000, 0, 0, 16'h0000);
      if (m_err) do_reset();

      // Randomized lists, terminators and allocator errors.
      for (int t = 0; t < 40; t++) begin
         if (m_err) do_reset();
         build_random(h, n);
         ac = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 2*n + 1) : 0;
         run_walk(h, ac, 0, 16'h0000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
